// File: rtl/ring_counter_nmode_if.sv
// Control/status bundle for ring_counter_nmode.
// The master side drives the step controls; the slave side is the counter itself.
interface ring_counter_nmode_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             illegal;

  modport master (
    output enable, mode, dir, load, load_value,
    input  q, wrap, illegal
  );

  modport slave (
    input  enable, mode, dir, load, load_value,
    output q, wrap, illegal
  );
endinterface

// File: rtl/ring_counter_nmode.sv
// Parametrised ring / Johnson shift counter with direction select, clock enable,
// parallel load, illegal-state self-correction and a registered wrap pulse.
module ring_counter_nmode #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  ring_counter_nmode_if.slave   io_bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("ring_counter_nmode: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_illegal;

  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-2:0] w_edges;
  logic             w_legal;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_next;
  logic             w_illegal_next;

  // Seed of the currently selected mode; also used for reset via mode on the reset edge.
  assign w_seed = io_bus.mode ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};

  // Bit i set where q[i] and q[i+1] differ; a Johnson code has at most one such edge.
  assign w_edges = r_q[WIDTH-1:1] ^ r_q[WIDTH-2:0];

  // Legality and shift are evaluated combinationally from the current state and mode.
  always_comb begin
    w_legal = 1'b0;
    w_shift = r_q;
    if (io_bus.mode) begin
      w_legal = ((w_edges & (w_edges - 1'b1)) == '0);
    end else begin
      w_legal = (r_q != '0) && ((r_q & (r_q - 1'b1)) == '0);
    end
    // Johnson feeds back the inverted end bit; ring feeds it back unchanged.
    if (io_bus.dir) begin
      w_shift = {r_q[0] ^ io_bus.mode, r_q[WIDTH-1:1]};
    end else begin
      w_shift = {r_q[WIDTH-2:0], r_q[WIDTH-1] ^ io_bus.mode};
    end
  end

  // Next-state selection: load > enabled step > hold (reset handled in the register).
  always_comb begin
    w_q_next       = r_q;
    w_wrap_next    = 1'b0;
    w_illegal_next = 1'b0;
    if (io_bus.load) begin
      w_q_next = io_bus.load_value;
    end else if (io_bus.enable) begin
      if (w_legal) begin
        w_q_next    = w_shift;
        w_wrap_next = (w_shift == w_seed);
      end else begin
        // Correction replaces the shift for this step and never counts as a wrap.
        w_q_next       = w_seed;
        w_illegal_next = 1'b1;
      end
    end
  end

  // State and pulse registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q       <= w_seed;
      r_wrap    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_wrap    <= w_wrap_next;
      r_illegal <= w_illegal_next;
    end
  end

  assign io_bus.q       = r_q;
  assign io_bus.wrap    = r_wrap;
  assign io_bus.illegal = r_illegal;

endmodule

// File: doc/ring_counter_nmode.md
# ring_counter_nmode

Parametrised shift-register counter, the successor to the fixed 4-bit ring counter. Provides one-hot ring and Johnson (twisted-ring) modes, selectable shift direction, clock enable, parallel load, self-correction of illegal states and a wrap pulse. Used as a phase/sequencer source for strobe generation and time-slot selection in the FPGA datapath.

## Interface
- WIDTH, 4: register width; legal range 2..32.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; loads the mode's seed.
- enable  in  1  advance one step on this edge when high.
- mode  in  1  0 = ring (one-hot), 1 = Johnson.
- dir  in  1  0 = shift toward MSB, 1 = shift toward LSB.
- load  in  1  parallel load request.
- load_value  in  WIDTH  value written on load.
- q  out  WIDTH  counter state, registered.
- wrap  out  1  registered one-cycle pulse: state returned to seed by a normal step.
- illegal  out  1  registered one-cycle pulse: illegal state was corrected on this step.

## Operation
- Seed: ring = {0..0,1} (bit 0 set); Johnson = all zeros. Seed uses `mode` sampled on the reset edge.
- Priority per edge: reset > load > enable > hold.
- Load: q <= load_value verbatim, no legality check at load; wrap = 0, illegal = 0.
- Step (enable = 1, no reset/load), from a legal state:
  - ring, dir 0: q <= {q[W-2:0], q[W-1]}; ring, dir 1: q <= {q[0], q[W-1:1]}.
  - Johnson, dir 0: q <= {q[W-2:0], ~q[W-1]}; Johnson, dir 1: q <= {~q[0], q[W-1:1]}.
- Legality, evaluated on current q against current `mode`:
  - ring: exactly one bit set.
  - Johnson: at most one i in 0..W-2 with q[i] != q[i+1] (2·WIDTH legal states).
- Step from an illegal state: q <= seed of current mode, illegal <= 1, wrap <= 0. No shift that cycle.
- wrap <= 1 only when a legal step produces the seed. Never on reset, load or correction.
- Period: ring = WIDTH steps, Johnson = 2·WIDTH steps, either direction.
- Hold (enable = 0): q unchanged; illegal state is kept until next enabled step.
- `mode`/`dir` may change any cycle; take effect on the next step. A mode change that makes q illegal is corrected on the next enabled step, not immediately.

## Timing
- Reset values: q = seed, wrap = 0, illegal = 0.
- Latency: one edge from enable/load to q; wrap and illegal align with the q update that caused them.
- wrap and illegal are 0 on every edge that is not a step; never high together.
- Reset mid-run overrides enable/load the same edge; outputs return to reset values.
- No combinational path input -> output.

## Test plan
- WIDTH=4, mode 0, dir 0, reset then enable held: q 0001, 0010, 0100, 1000, 0001; wrap = 1 only with the final 0001; illegal stays 0.
- Mode 1, dir 0 from reset: q 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap on the 8th step only. Repeat with dir 1: 0000, 1000, 1100, ...
- Mode 0, dir 1, load 0100, then enable: 0010, 0001, 1000, 0100; wrap with the 0001 step; toggle enable low mid-sequence -> q holds, wrap 0.
- Illegal recovery: mode 0, load 0110, step -> q 0001, illegal 1, wrap 0. Mode 1, load 0101, step -> q 0000, illegal 1. Mode 1, load 0011, step -> q 0111, illegal 0.
- Mode switch: running mode 0 at 0100, set mode 1, step -> q 0000, illegal 1. Running mode 0 at 0001, set mode 1 (0001 is Johnson-legal), step -> 0011, illegal 0.
- Reset priority: reset, load = 1 (load_value 1010) and enable = 1 on the same edge with mode 0 -> q 0001, wrap 0, illegal 0. Repeat with WIDTH=2 and WIDTH=8 to confirm ring/Johnson periods of WIDTH and 2·WIDTH.
